// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, receive FSM states and
// the decoded-word bundle passed between decoder stages.
package tmds_pkg;

    localparam logic [9:0] TOKEN_CTL0 = 10'b1101010100;
    localparam logic [9:0] TOKEN_CTL1 = 10'b0010101011;
    localparam logic [9:0] TOKEN_CTL2 = 10'b0101010100;
    localparam logic [9:0] TOKEN_CTL3 = 10'b1010101011;

    localparam int MAX_DATA_TRANSITIONS = 4;

    typedef enum logic [1:0] {
        SEARCH,
        SLIP_WAIT,
        LOCKED
    } decoderState_t;

    typedef struct packed {
        logic       isToken;
        logic [1:0] ctl;
        logic [7:0] data;
        logic       invalid;
    } decodedWord_t;

    function automatic logic [3:0] countTransitions(input logic [7:0] bits);
        logic [3:0] n;
        n = '0;
        for (int i = 1; i < 8; i++) begin
            n = n + 4'(bits[i] ^ bits[i-1]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_word_decoder.sv
// Combinational TMDS word classifier: control token lookup, video data
// decode and detection of data words with too many bit transitions.
module tmds_word_decoder
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic       isToken,
    output logic [1:0] ctl,
    output logic [7:0] data,
    output logic       invalid
);

    logic [7:0] d;
    logic [6:0] chain;

    always_comb begin
        isToken = 1'b1;
        ctl     = 2'b00;
        unique case (1'b1)
            (word == TOKEN_CTL0): ctl = 2'b00;
            (word == TOKEN_CTL1): ctl = 2'b01;
            (word == TOKEN_CTL2): ctl = 2'b10;
            (word == TOKEN_CTL3): ctl = 2'b11;
            default:              isToken = 1'b0;
        endcase
    end

    // bit 9 undoes DC-balance inversion, bit 8 selects XOR vs XNOR chain
    assign d     = word[9] ? ~word[7:0] : word[7:0];
    assign chain = d[7:1] ^ d[6:0];
    assign data  = {word[8] ? chain : ~chain, d[0]};

    assign invalid = !isToken &&
        (countTransitions(word[7:0]) > 4'(MAX_DATA_TRANSITIONS));

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: bitslip-driven symbol alignment on control
// tokens, then token/video decode through a two-stage pipeline.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT     = 32,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int SLIP_SETTLE    = 4,
    parameter int LOSS_TIMEOUT   = 2048
) (
    input  logic       pixelClock,
    input  logic       resetN,
    input  logic [9:0] tmdsWord,
    output logic       bitslip,
    output logic       aligned,
    output logic       DE,
    output logic [7:0] pixelComponent,
    output logic [1:0] controlBus,
    output logic       codingError
);

    localparam int RUN_W    = $clog2(LOCK_COUNT + 1);
    localparam int SEARCH_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SETTLE_W = $clog2(SLIP_SETTLE + 1);
    localparam int LOSS_W   = $clog2(LOSS_TIMEOUT + 1);

    logic          curIsToken;
    logic [1:0]    curCtl;
    logic [7:0]    curData;
    logic          curInvalid;
    decodedWord_t  s1;
    decoderState_t state;
    decoderState_t stateNext;
    logic          slipReq;

    logic [RUN_W-1:0]    tokenRun;
    logic [SEARCH_W-1:0] searchTimer;
    logic [SETTLE_W-1:0] settleTimer;
    logic [LOSS_W-1:0]   lossTimer;

    tmds_word_decoder wordDecoder (
        .word    (tmdsWord),
        .isToken (curIsToken),
        .ctl     (curCtl),
        .data    (curData),
        .invalid (curInvalid)
    );

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            s1 <= '0;
        end else begin
            s1 <= decodedWord_t'{
                isToken: curIsToken,
                ctl:     curCtl,
                data:    curData,
                invalid: curInvalid
            };
        end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) state <= SEARCH;
        else         state <= stateNext;
    end

    // lock is checked before the slip timeout so it wins a tie
    always_comb begin
        stateNext = state;
        slipReq   = 1'b0;
        unique case (state)
            SEARCH: begin
                if (curIsToken &&
                    tokenRun == RUN_W'(LOCK_COUNT - 1)) begin
                    stateNext = LOCKED;
                end else if (searchTimer ==
                             SEARCH_W'(SEARCH_TIMEOUT - 1)) begin
                    stateNext = SLIP_WAIT;
                    slipReq   = 1'b1;
                end
            end
            SLIP_WAIT: begin
                if (settleTimer == SETTLE_W'(SLIP_SETTLE - 1))
                    stateNext = SEARCH;
            end
            LOCKED: begin
                if (!curIsToken &&
                    lossTimer == LOSS_W'(LOSS_TIMEOUT - 1))
                    stateNext = SEARCH;
            end
            default: stateNext = SEARCH;
        endcase
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            tokenRun    <= '0;
            searchTimer <= '0;
            settleTimer <= '0;
            lossTimer   <= '0;
        end else if (stateNext != state) begin
            tokenRun    <= '0;
            searchTimer <= '0;
            settleTimer <= '0;
            lossTimer   <= '0;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (!curIsToken)
                        tokenRun <= '0;
                    else if (tokenRun != RUN_W'(LOCK_COUNT))
                        tokenRun <= tokenRun + RUN_W'(1);
                    if (searchTimer != SEARCH_W'(SEARCH_TIMEOUT))
                        searchTimer <= searchTimer + SEARCH_W'(1);
                end
                SLIP_WAIT: begin
                    if (settleTimer != SETTLE_W'(SLIP_SETTLE))
                        settleTimer <= settleTimer + SETTLE_W'(1);
                end
                LOCKED: begin
                    if (curIsToken)
                        lossTimer <= '0;
                    else if (lossTimer != LOSS_W'(LOSS_TIMEOUT))
                        lossTimer <= lossTimer + LOSS_W'(1);
                end
                default: ;
            endcase
        end
    end

    // gating on the next state keeps outputs and aligned in step
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            bitslip        <= 1'b0;
            aligned        <= 1'b0;
            DE             <= 1'b0;
            pixelComponent <= '0;
            controlBus     <= '0;
            codingError    <= 1'b0;
        end else begin
            bitslip <= slipReq;
            aligned <= (stateNext == LOCKED);
            if (stateNext != LOCKED) begin
                DE             <= 1'b0;
                pixelComponent <= '0;
                controlBus     <= '0;
                codingError    <= 1'b0;
            end else begin
                DE          <= !s1.isToken;
                codingError <= s1.invalid;
                if (s1.isToken) controlBus     <= s1.ctl;
                else            pixelComponent <= s1.data;
            end
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: scoreboarded decode checks, lock/loss
// timing, asynchronous reset and bitslip alignment of a skewed stream.
`timescale 1ns/1ps
module tb_tmds_channel_decoder;

    localparam logic [9:0] T00 = 10'h354;
    localparam logic [9:0] T01 = 10'h0AB;
    localparam logic [9:0] T10 = 10'h154;
    localparam logic [9:0] T11 = 10'h2AB;

    logic       pixelClock = 1'b0;
    logic       resetN = 1'b0;
    logic [9:0] tmdsWord = 10'h100;
    logic       bitslip;
    logic       aligned;
    logic       DE;
    logic [7:0] pixelComponent;
    logic [1:0] controlBus;
    logic       codingError;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    typedef struct {
        int         due;
        logic       de;
        logic [7:0] pix;
        logic [1:0] ctl;
        logic       err;
    } sbEntry_t;

    sbEntry_t   sbQ[$];
    sbEntry_t   sbHead;
    logic [9:0] lineWords[858];

    tmds_channel_decoder dut (
        .pixelClock     (pixelClock),
        .resetN         (resetN),
        .tmdsWord       (tmdsWord),
        .bitslip        (bitslip),
        .aligned        (aligned),
        .DE             (DE),
        .pixelComponent (pixelComponent),
        .controlBus     (controlBus),
        .codingError    (codingError)
    );

    always #5 pixelClock = ~pixelClock;

    always @(posedge pixelClock) cycleCount <= cycleCount + 1;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, want, cycleCount);
        end
    endtask

    always @(negedge pixelClock) begin
        if (sbQ.size() > 0 && sbQ[0].due <= cycleCount) begin
            sbHead = sbQ.pop_front();
            checkVal("sbDE", 32'(DE), 32'(sbHead.de));
            checkVal("sbPix", 32'(pixelComponent), 32'(sbHead.pix));
            checkVal("sbCtl", 32'(controlBus), 32'(sbHead.ctl));
            checkVal("sbErr", 32'(codingError), 32'(sbHead.err));
        end
    end

    task automatic sendWord(input logic [9:0] w);
        @(posedge pixelClock);
        #1;
        tmdsWord = w;
    endtask

    task automatic expectOut(input logic de, input logic [7:0] pix,
                             input logic [1:0] ctl, input logic err);
        sbEntry_t e;
        e.due = cycleCount + 2;
        e.de  = de;
        e.pix = pix;
        e.ctl = ctl;
        e.err = err;
        sbQ.push_back(e);
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, "Al"}, 32'(aligned), 0);
        checkVal({tag, "Slip"}, 32'(bitslip), 0);
        checkVal({tag, "DE"}, 32'(DE), 0);
        checkVal({tag, "Pix"}, 32'(pixelComponent), 0);
        checkVal({tag, "Ctl"}, 32'(controlBus), 0);
        checkVal({tag, "Err"}, 32'(codingError), 0);
    endtask

    task automatic lockOnTokens(input string tag);
        for (int i = 0; i < 40; i++) begin
            sendWord(T00);
            expectOut(1'b0, 8'h00, 2'b00, 1'b0);
            @(negedge pixelClock);
            checkVal(tag, 32'(aligned), 32'(i >= 32));
            checkVal("slipQuiet", 32'(bitslip), 0);
        end
    endtask

    task automatic pulseReset();
        @(posedge pixelClock);
        #1 resetN = 1'b0;
        tmdsWord = 10'h100;
        repeat (2) @(posedge pixelClock);
        #1 resetN = 1'b1;
    endtask

    function automatic logic [9:0] streamWord(input int pos);
        logic [9:0] w;
        logic [9:0] src;
        int p;
        for (int b = 0; b < 10; b++) begin
            p = pos + b;
            src = lineWords[(p / 10) % 858];
            w[b] = src[p % 10];
        end
        return w;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int firstSlip;
        int pos;
        int slips;
        int lastSlip;
        int extra;
        int dropped;

        for (int i = 0; i < 858; i++)
            lineWords[i] = (i < 138) ? T00 : ((i % 2) ? 10'h0FF : 10'h100);

        repeat (3) @(posedge pixelClock);
        @(negedge pixelClock);
        checkZero("rst");
        @(posedge pixelClock);
        #1 resetN = 1'b1;

        lockOnTokens("lockRise");

        sendWord(10'h100); expectOut(1'b1, 8'h00, 2'b00, 1'b0);
        sendWord(10'h0FF); expectOut(1'b1, 8'hFF, 2'b00, 1'b0);
        sendWord(T00);     expectOut(1'b0, 8'hFF, 2'b00, 1'b0);
        sendWord(T01);     expectOut(1'b0, 8'hFF, 2'b01, 1'b0);
        sendWord(T10);     expectOut(1'b0, 8'hFF, 2'b10, 1'b0);
        sendWord(T11);     expectOut(1'b0, 8'hFF, 2'b11, 1'b0);
        sendWord(10'h155); expectOut(1'b1, 8'hFF, 2'b11, 1'b1);
        sendWord(T00);     expectOut(1'b0, 8'hFF, 2'b00, 1'b0);
        sendWord(10'h2E3); expectOut(1'b1, 8'hDA, 2'b00, 1'b0);
        sendWord(10'h3C1); expectOut(1'b1, 8'h42, 2'b00, 1'b0);
        sendWord(10'h100); expectOut(1'b1, 8'h00, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sendWord(T00);
            expectOut(1'b0, 8'h00, 2'b00, 1'b0);
        end
        @(negedge pixelClock);
        checkVal("alignHold", 32'(aligned), 1);

        firstSlip = 0;
        for (int n = 1; n <= 3100; n++) begin
            sendWord(10'h100);
            @(negedge pixelClock);
            if (n == 2048) begin
                checkVal("lossHoldAl", 32'(aligned), 1);
                checkVal("lossHoldDE", 32'(DE), 1);
            end
            if (n == 2049) begin
                checkVal("lossDropAl", 32'(aligned), 0);
                checkVal("lossDropDE", 32'(DE), 0);
            end
            if (bitslip && firstSlip == 0) firstSlip = n;
        end
        checkVal("slipResume", firstSlip, 3073);

        pulseReset();
        lockOnTokens("relock");
        sendWord(10'h0FF); expectOut(1'b1, 8'hFF, 2'b00, 1'b0);
        sendWord(10'h0FF);
        sendWord(10'h0FF);
        @(negedge pixelClock);
        checkVal("preRstAl", 32'(aligned), 1);
        checkVal("preRstDE", 32'(DE), 1);
        #2 resetN = 1'b0;
        #1 checkZero("asyncRst");
        repeat (2) @(posedge pixelClock);
        #1 resetN = 1'b1;
        lockOnTokens("freshLock");

        pulseReset();
        pos = 3;
        slips = 0;
        lastSlip = 0;
        for (int c = 0; c < 12000 && aligned == 1'b0; c++) begin
            @(posedge pixelClock);
            #1;
            if (bitslip) begin
                if (slips > 0)
                    checkVal("slipGap", cycleCount - lastSlip, 1028);
                lastSlip = cycleCount;
                slips++;
                pos++;
            end
            tmdsWord = streamWord(pos);
            pos += 10;
        end
        checkVal("slipCount", slips, 7);
        checkVal("streamLock", 32'(aligned), 1);

        extra = 0;
        dropped = 0;
        for (int c = 0; c < 2500; c++) begin
            @(posedge pixelClock);
            #1;
            if (bitslip) extra++;
            if (!aligned) dropped++;
            tmdsWord = streamWord(pos);
            pos += 10;
        end
        checkVal("slipAfterLock", extra, 0);
        checkVal("lockKept", dropped, 0);
        checkVal("sbDrain", sbQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
